// File: rtl/resp_scoreboard_pkg.sv
// Shared constants, error-bit indices and pending-entry record for resp_scoreboard.
// Defining RESP_SCOREBOARD_TIMEOUT_EN adds the watchdog error bit and widens err_code to 4 bits.
package cdc_chk_pkg;

    localparam int OP_BIT   = 16;
    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    localparam int ERR_MISMATCH   = 0;
    localparam int ERR_OVERFLOW   = 1;
    localparam int ERR_UNEXPECTED = 2;
`ifdef RESP_SCOREBOARD_TIMEOUT_EN
    localparam int ERR_TIMEOUT    = 3;
    localparam int ERR_W          = 4;
`else
    localparam int ERR_W          = 3;
`endif

    typedef struct packed {
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [7:0] addr;
    } pend_entry_t;

    function automatic logic [7:0] cmd_addr(input logic [16:0] word);
        return word[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [7:0] cmd_data(input logic [16:0] word);
        return word[DATA_MSB:0];
    endfunction

endpackage

// File: rtl/resp_scoreboard_if.sv
// Snoop bundle for the command-FIFO write side and response-FIFO read side.
// master drives the FIFO handshakes; slave is the passive scoreboard view.
interface resp_scoreboard_if;

    logic        cmd_wr_en;
    logic [16:0] cmd_wr_data;
    logic        cmd_full;
    logic        resp_rd_en;
    logic [7:0]  resp_rd_data;
    logic        resp_empty;

    modport master (
        output cmd_wr_en, cmd_wr_data, cmd_full,
        output resp_rd_en, resp_rd_data, resp_empty
    );

    modport slave (
        input cmd_wr_en, cmd_wr_data, cmd_full,
        input resp_rd_en, resp_rd_data, resp_empty
    );

endinterface

// File: rtl/resp_scoreboard_fifo.sv
// chk_sync_fifo: single-clock show-ahead FIFO holding outstanding read expectations.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module chk_sync_fifo #(
    parameter int AW = 4,
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    // A pop frees the slot a push on a full queue needs in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/resp_scoreboard.sv
// resp_scoreboard: shadows snooped writes and checks each read response against the value seen at read issue.
// RESP_SCOREBOARD_TIMEOUT_EN adds a watchdog that flags reads left unanswered for TIMEOUT_CYCLES.
module resp_scoreboard
    import cdc_chk_pkg::*;
#(
    parameter int PEND_AW        = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    resp_scoreboard_if.slave   bus,
    output logic [CNT_W-1:0]   check_cnt,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic [CNT_W-1:0]   unchecked_cnt,
    output logic [PEND_AW:0]   pending_cnt,
    output logic               err_sticky,
    output logic [7:0]         first_err_addr,
    output logic [7:0]         first_err_exp,
    output logic [7:0]         first_err_got,
    output logic [ERR_W-1:0]   err_code
);

    logic        cmd_acc;
    logic        wr_acc;
    logic        rd_acc;
    logic        resp_acc;
    logic [7:0]  op_addr;
    logic [7:0]  op_data;

    logic [7:0]   shadow [0:255];
    logic [255:0] valid_bits;

    pend_entry_t push_entry;
    pend_entry_t head_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop_ok;
    logic        overflow;
    logic        unexpected;

    logic        cmp_vld;
    pend_entry_t cmp_entry;
    logic [7:0]  cmp_got;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cmd_acc  = bus.cmd_wr_en && !bus.cmd_full;
    assign wr_acc   = cmd_acc && bus.cmd_wr_data[OP_BIT];
    assign rd_acc   = cmd_acc && !bus.cmd_wr_data[OP_BIT];
    assign resp_acc = bus.resp_rd_en && !bus.resp_empty;
    assign op_addr  = cmd_addr(bus.cmd_wr_data);
    assign op_data  = cmd_data(bus.cmd_wr_data);

    // Snapshot is taken from pre-edge shadow contents, so a later write cannot alter it.
    assign push_entry = '{exp_valid: valid_bits[op_addr], exp_data: shadow[op_addr], addr: op_addr};

    assign pop_ok     = resp_acc && !fifo_empty;
    assign unexpected = resp_acc && fifo_empty;
    assign overflow   = rd_acc && fifo_full && !pop_ok;

    chk_sync_fifo #(
        .AW (PEND_AW),
        .DW ($bits(pend_entry_t))
    ) u_pend_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_acc),
        .wdata (push_entry),
        .pop   (resp_acc),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_bits <= '0;
        end else if (wr_acc) begin
            valid_bits[op_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) shadow[op_addr] <= op_data;
    end

    always_ff @(posedge clk) begin
        cmp_entry <= head_entry;
        cmp_got   <= bus.resp_rd_data;
    end

`ifdef RESP_SCOREBOARD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;

    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (resp_acc || pending_cnt == '0) begin
            wd_cnt <= '0;
        end else if (!wd_hit) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`endif

    // Comparison runs one cycle after the pop, from the registered head entry and response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_vld        <= 1'b0;
            check_cnt      <= '0;
            mismatch_cnt   <= '0;
            unchecked_cnt  <= '0;
            err_code       <= '0;
            err_sticky     <= 1'b0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
        end else begin
            cmp_vld <= pop_ok;
            if (cmp_vld) begin
                if (cmp_entry.exp_valid) begin
                    check_cnt <= sat_inc(check_cnt);
                    if (cmp_entry.exp_data != cmp_got) begin
                        mismatch_cnt           <= sat_inc(mismatch_cnt);
                        err_code[ERR_MISMATCH] <= 1'b1;
                        if (!err_code[ERR_MISMATCH]) begin
                            first_err_addr <= cmp_entry.addr;
                            first_err_exp  <= cmp_entry.exp_data;
                            first_err_got  <= cmp_got;
                        end
                    end
                end else begin
                    unchecked_cnt <= sat_inc(unchecked_cnt);
                end
            end
            if (overflow)   err_code[ERR_OVERFLOW]   <= 1'b1;
            if (unexpected) err_code[ERR_UNEXPECTED] <= 1'b1;
`ifdef RESP_SCOREBOARD_TIMEOUT_EN
            if (wd_hit)     err_code[ERR_TIMEOUT]    <= 1'b1;
`endif
            err_sticky <= |err_code;
        end
    end

endmodule

// File: tb/tb_resp_scoreboard.sv
// Self-checking bench for resp_scoreboard: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_resp_scoreboard;
    import cdc_chk_pkg::*;

    localparam int PEND_AW = 4;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int DEPTH   = 1 << PEND_AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    resp_scoreboard_if bus();

    logic [CNT_W-1:0] check_cnt, mismatch_cnt, unchecked_cnt;
    logic [PEND_AW:0] pending_cnt;
    logic             err_sticky;
    logic [7:0]       first_err_addr, first_err_exp, first_err_got;
    logic [ERR_W-1:0] err_code;

    resp_scoreboard #(
        .PEND_AW        (PEND_AW),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .check_cnt      (check_cnt),
        .mismatch_cnt   (mismatch_cnt),
        .unchecked_cnt  (unchecked_cnt),
        .pending_cnt    (pending_cnt),
        .err_sticky     (err_sticky),
        .first_err_addr (first_err_addr),
        .first_err_exp  (first_err_exp),
        .first_err_got  (first_err_got),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state: shadow memory, expectation queue, and results due next edge.
    logic [7:0]       m_shadow [0:255];
    logic             m_valid  [0:255];
    pend_entry_t      mq[$];
    logic [CNT_W-1:0] m_check, m_mism, m_unchk;
    logic [ERR_W-1:0] m_err, old_err;
    logic             m_sticky;
    logic [7:0]       m_fa, m_fe, m_fg;
    logic             d_vld;
    pend_entry_t      d_entry;
    logic [7:0]       d_got;
    int               m_wd;
    int               old_size;
    logic             c_acc, r_acc;
    logic [7:0]       m_a;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
            m_check = '0; m_mism = '0; m_unchk = '0;
            m_err = '0; m_sticky = 1'b0;
            m_fa = '0; m_fe = '0; m_fg = '0;
            d_vld = 1'b0; m_wd = 0;
        end else begin
            old_err  = m_err;
            old_size = mq.size();
            if (d_vld) begin
                if (d_entry.exp_valid) begin
                    m_check = bump(m_check);
                    if (d_entry.exp_data != d_got) begin
                        m_mism = bump(m_mism);
                        if (!m_err[ERR_MISMATCH]) begin
                            m_fa = d_entry.addr; m_fe = d_entry.exp_data; m_fg = d_got;
                        end
                        m_err[ERR_MISMATCH] = 1'b1;
                    end
                end else begin
                    m_unchk = bump(m_unchk);
                end
                d_vld = 1'b0;
            end
            m_sticky = |old_err;
            c_acc = bus.cmd_wr_en && !bus.cmd_full;
            r_acc = bus.resp_rd_en && !bus.resp_empty;
            m_a   = bus.cmd_wr_data[15:8];
            if (r_acc) begin
                if (mq.size() == 0) m_err[ERR_UNEXPECTED] = 1'b1;
                else begin
                    d_entry = mq.pop_front();
                    d_got   = bus.resp_rd_data;
                    d_vld   = 1'b1;
                end
            end
            if (c_acc && !bus.cmd_wr_data[16]) begin
                if (mq.size() >= DEPTH) m_err[ERR_OVERFLOW] = 1'b1;
                else mq.push_back('{exp_valid: m_valid[m_a], exp_data: m_shadow[m_a], addr: m_a});
            end
            if (c_acc && bus.cmd_wr_data[16]) begin
                m_shadow[m_a] = bus.cmd_wr_data[7:0];
                m_valid[m_a]  = 1'b1;
            end
`ifdef RESP_SCOREBOARD_TIMEOUT_EN
            if (m_wd == TIMEOUT) m_err[ERR_TIMEOUT] = 1'b1;
            if (r_acc || old_size == 0) m_wd = 0;
            else if (m_wd < TIMEOUT) m_wd++;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("check_cnt",      32'(check_cnt),      32'(m_check));
            checkOutput("mismatch_cnt",   32'(mismatch_cnt),   32'(m_mism));
            checkOutput("unchecked_cnt",  32'(unchecked_cnt),  32'(m_unchk));
            checkOutput("pending_cnt",    32'(pending_cnt),    32'(mq.size()));
            checkOutput("err_code",       32'(err_code),       32'(m_err));
            checkOutput("err_sticky",     32'(err_sticky),     32'(m_sticky));
            checkOutput("first_err_addr", 32'(first_err_addr), 32'(m_fa));
            checkOutput("first_err_exp",  32'(first_err_exp),  32'(m_fe));
            checkOutput("first_err_got",  32'(first_err_got),  32'(m_fg));
        end
    end

    task automatic applyStimulus(input logic c_en, input logic c_full, input logic op,
                                 input logic [7:0] addr, input logic [7:0] data,
                                 input logic r_en, input logic r_empty, input logic [7:0] r_data);
        bus.cmd_wr_en    = c_en;
        bus.cmd_full     = c_full;
        bus.cmd_wr_data  = {op, addr, data};
        bus.resp_rd_en   = r_en;
        bus.resp_empty   = r_empty;
        bus.resp_rd_data = r_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        applyStimulus(1, 0, 1, a, d, 0, 1, 8'h00);
    endtask

    task automatic rd(input logic [7:0] a);
        applyStimulus(1, 0, 0, a, 8'h00, 0, 1, 8'h00);
    endtask

    task automatic rsp(input logic [7:0] d);
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 0, d);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    logic       s_cen, s_full, s_op, s_ren, s_remp;
    logic [7:0] s_addr, s_data, s_rdat;

    initial begin
        bus.cmd_wr_en = 0; bus.cmd_full = 0; bus.cmd_wr_data = '0;
        bus.resp_rd_en = 0; bus.resp_empty = 1; bus.resp_rd_data = '0;
        @(negedge clk);
        doReset();
        chk_en = 1'b1;

        checkOutput("reset_check_cnt",  32'(check_cnt),   32'h0);
        checkOutput("reset_pending",    32'(pending_cnt), 32'h0);
        checkOutput("reset_err_code",   32'(err_code),    32'h0);

        wr(8'h05, 8'hA5); rd(8'h05); rsp(8'hA5); idle(3);
        checkOutput("match_check_cnt",  32'(check_cnt),    32'h1);
        checkOutput("match_mismatch",   32'(mismatch_cnt), 32'h0);
        checkOutput("match_sticky",     32'(err_sticky),   32'h0);

        doReset();
        wr(8'h10, 8'h3C); rd(8'h10); rsp(8'h3D); idle(3);
        checkOutput("mism_cnt",         32'(mismatch_cnt),   32'h1);
        checkOutput("mism_first_addr",  32'(first_err_addr), 32'h10);
        checkOutput("mism_first_exp",   32'(first_err_exp),  32'h3C);
        checkOutput("mism_first_got",   32'(first_err_got),  32'h3D);
        checkOutput("mism_err_bit",     32'(err_code[ERR_MISMATCH]), 32'h1);
        checkOutput("mism_sticky",      32'(err_sticky),     32'h1);
        wr(8'h11, 8'h01); rd(8'h11); rsp(8'h02); idle(3);
        checkOutput("mism2_cnt",        32'(mismatch_cnt),   32'h2);
        checkOutput("mism2_first_addr", 32'(first_err_addr), 32'h10);

        doReset();
        rd(8'h20); wr(8'h20, 8'h77); rsp(8'h00); idle(3);
        checkOutput("unchk_cnt",        32'(unchecked_cnt), 32'h1);
        checkOutput("unchk_mismatch",   32'(mismatch_cnt),  32'h0);
        checkOutput("unchk_check_cnt",  32'(check_cnt),     32'h0);

        doReset();
        for (int i = 0; i < 17; i++) rd(8'(i));
        idle(2);
        checkOutput("ovf_pending",      32'(pending_cnt), 32'd16);
        checkOutput("ovf_err_code",     32'(err_code),    32'h2);

        doReset();
        for (int i = 0; i < 16; i++) rd(8'h02);
        applyStimulus(1, 0, 0, 8'h02, 8'h00, 1, 0, 8'h00);
        idle(2);
        checkOutput("full_pushpop_err", 32'(err_code),      32'h0);
        checkOutput("full_pushpop_pend",32'(pending_cnt),   32'd16);
        checkOutput("full_pushpop_unck",32'(unchecked_cnt), 32'h1);

        doReset();
        rsp(8'h55); idle(3);
        checkOutput("unexp_err_code",   32'(err_code),  32'h4);
        checkOutput("unexp_check_cnt",  32'(check_cnt), 32'h0);

        doReset();
        applyStimulus(1, 0, 0, 8'h03, 8'h00, 1, 0, 8'h00);
        idle(3);
        checkOutput("empty_pushpop_err",  32'(err_code),      32'h4);
        checkOutput("empty_pushpop_pend", 32'(pending_cnt),   32'h1);
        checkOutput("empty_pushpop_unck", 32'(unchecked_cnt), 32'h0);

        doReset();
        wr(8'h01, 8'h11); rd(8'h01);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 8'h01, 8'h00, 1, 0, 8'h11);
        rsp(8'h11); idle(3);
        checkOutput("sat_check_cnt",    32'(check_cnt),   32'hF);
        checkOutput("sat_pending",      32'(pending_cnt), 32'h0);

        doReset();
        wr(8'h03, 8'h33); rd(8'h03); rd(8'h03);
        doReset();
        rsp(8'h33); idle(3);
        checkOutput("midrst_err_code",  32'(err_code),    32'h4);
        checkOutput("midrst_pending",   32'(pending_cnt), 32'h0);
        checkOutput("midrst_check_cnt", 32'(check_cnt),   32'h0);

`ifdef RESP_SCOREBOARD_TIMEOUT_EN
        doReset();
        rd(8'h40); idle(40);
        checkOutput("wd_early",         32'(err_code[ERR_TIMEOUT]), 32'h0);
        idle(40);
        checkOutput("wd_fired",         32'(err_code[ERR_TIMEOUT]), 32'h1);
        doReset();
        checkOutput("wd_rst_err_code",  32'(err_code),    32'h0);
        checkOutput("wd_rst_pending",   32'(pending_cnt), 32'h0);
        checkOutput("wd_rst_sticky",    32'(err_sticky),  32'h0);
`endif

        doReset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end else begin
                s_cen  = 1'($urandom_range(0, 1));
                s_full = ($urandom_range(0, 6) == 0);
                s_op   = ($urandom_range(0, 4) < 2);
                s_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
                s_data = 8'($urandom);
                s_ren  = ($urandom_range(0, 9) < 4);
                s_remp = ($urandom_range(0, 6) == 0);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0) s_rdat = mq[0].exp_data;
                else s_rdat = 8'($urandom);
                applyStimulus(s_cen, s_full, s_op, s_addr, s_data, s_ren, s_remp, s_rdat);
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/resp_scoreboard.md
RESP_SCOREBOARD -- requirements
Module: resp_scoreboard

Interface
REQ-001 SHALL have parameter PEND_AW, default 4, giving a pending-read queue of 2^PEND_AW entries.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of every counter output.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the watchdog limit in clk cycles.
REQ-004 clk  in  1  90 MHz master-domain clock; single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 cmd_wr_en  in  1  snoop of command FIFO write enable.
REQ-007 cmd_wr_data  in  17  snoop of command word: [16] op (1 = write), [15:8] addr, [7:0] data.
REQ-008 cmd_full  in  1  snoop of command FIFO full.
REQ-009 resp_rd_en  in  1  snoop of response FIFO read enable.
REQ-010 resp_rd_data  in  8  snoop of response FIFO read data.
REQ-011 resp_empty  in  1  snoop of response FIFO empty.
REQ-012 check_cnt  out  CNT_W  responses compared against a known expected value.
REQ-013 mismatch_cnt  out  CNT_W  compared responses that differed.
REQ-014 unchecked_cnt  out  CNT_W  responses to never-written addresses.
REQ-015 pending_cnt  out  PEND_AW+1  reads issued and not yet answered.
REQ-016 err_sticky  out  1  any error seen since reset.
REQ-017 first_err_addr / first_err_exp / first_err_got  out  8 each  capture of the first mismatch.
REQ-018 err_code  out  3  sticky flags: [0] mismatch, [1] queue overflow, [2] unexpected response.

Function
REQ-019 Accepted command SHALL be defined as cmd_wr_en & !cmd_full; accepted response SHALL be defined as resp_rd_en & !resp_empty; resp_rd_data SHALL be sampled in the same cycle.
REQ-020 Accepted write SHALL update shadow[addr] <= data and set valid[addr] on the next edge; shadow SHALL be 256x8 with 256 valid bits.
REQ-021 Accepted read SHALL push {valid[addr], shadow[addr], addr} into the pending queue, using shadow contents from before the current edge.
REQ-022 Accepted response SHALL pop the queue head in the same cycle; the comparison and the counter update SHALL be registered one cycle later.
REQ-023 Popped entry with valid=1 SHALL increment check_cnt and, if data differs, SHALL also increment mismatch_cnt and set err_code[0].
REQ-024 Popped entry with valid=0 SHALL increment only unchecked_cnt.
REQ-025 First mismatch only SHALL load first_err_*; later mismatches SHALL leave them unchanged.
REQ-026 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-027 Read accepted with the queue full and no same-cycle pop SHALL be dropped, SHALL set err_code[1], and SHALL leave pending_cnt unchanged.
REQ-028 Response accepted with the queue empty SHALL set err_code[2] and SHALL NOT be compared.
REQ-029 Simultaneous push and pop on an empty queue SHALL be handled as REQ-028 followed by the push.
REQ-030 Simultaneous push and pop on a full queue SHALL both proceed, with no overflow flagged.
REQ-031 Queue pointers SHALL wrap modulo 2^PEND_AW and SHALL carry one extra bit to distinguish full from empty.
REQ-032 err_sticky SHALL equal |err_code, registered.

Reset
REQ-033 rst_n low at a clk edge SHALL clear all counters, the queue pointers, err_code, err_sticky, first_err_* and every valid bit; shadow data is don't-care.
REQ-034 Reset asserted mid-transaction SHALL discard all pending entries, and responses arriving afterwards SHALL follow REQ-028.

Configuration
REQ-035 Macro RESP_SCOREBOARD_TIMEOUT_EN defined SHALL add a watchdog counter.
REQ-036 The watchdog SHALL clear on every accepted response or whenever pending_cnt = 0, and SHALL otherwise increment.
REQ-037 Watchdog reaching TIMEOUT_CYCLES SHALL set err_code bit [3], widening err_code to 4 bits, and the counter SHALL then hold.
REQ-038 Macro undefined SHALL leave no watchdog logic and a 3-bit err_code.

Structure
REQ-039 Package cdc_chk_pkg SHALL hold the OP_BIT=16, ADDR_MSB=15, ADDR_LSB=8 and DATA_MSB=7 constants, the err_code bit indices, and the pending-entry struct {exp_valid, exp_data, addr}.
REQ-040 The pending queue SHALL be sub-module chk_sync_fifo: a synchronous FIFO with a full/empty/count interface, instantiated once.

Verification
REQ-041 Write 0x05 <- 0xA5, read 0x05, then response 0xA5 -> check_cnt=1, mismatch_cnt=0, err_sticky=0.
REQ-042 Write 0x10 <- 0x3C, read 0x10, then response 0x3D -> mismatch_cnt=1, first_err_addr=0x10, first_err_exp=0x3C, first_err_got=0x3D, err_code[0]=1.
REQ-043 Read 0x20, write 0x20 <- 0x77, then response 0x00 -> unchecked_cnt=1, no mismatch (the snapshot is taken at read issue).
REQ-044 Seventeen reads with PEND_AW=4 and no responses -> pending_cnt=16, err_code[1]=1.
REQ-045 Response with no read outstanding -> err_code[2]=1, check_cnt=0.
REQ-046 With RESP_SCOREBOARD_TIMEOUT_EN and TIMEOUT_CYCLES=64, one read and no response -> err_code[3]=1 at 64 cycles; assert rst_n mid-run -> all outputs 0.
